// File: rtl/duc_mc_fs4.sv
// duc_mc_fs4: FIFO-fed I/Q to real fs/4 upconverter with INTERP-fold hold; define DUC_SAT_CNT_EN to add sat_count.
// Latency: a push on edge k gives first output on edge k+1 from IDLE; in_ready drops only when the FIFO is full.
module duc_mc_fs4 #(
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int INTERP     = 4,
  parameter int INV        = 0
) (
  input  logic              sys_clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] i_signal,
  input  logic [DATA_W-1:0] q_signal,
  input  logic              enable,
  output logic              valid,
  output logic [DATA_W-1:0] rf_output,
  output logic              empty,
  output logic              underrun
`ifdef DUC_SAT_CNT_EN
  ,
  output logic [15:0]       sat_count
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = (INTERP > 1) ? $clog2(INTERP) : 1;
  localparam logic [AW:0]       FULL_CNT = (AW+1)'(FIFO_DEPTH);
  localparam logic [CW-1:0]     LAST_CNT = CW'(INTERP - 1);
  localparam logic [DATA_W-1:0] MIN_V    = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [DATA_W-1:0] MAX_V    = {1'b0, {(DATA_W-1){1'b1}}};

  typedef enum logic {IDLE, RUN} state_t;

  logic [DATA_W-1:0] r_mem_i [FIFO_DEPTH];
  logic [DATA_W-1:0] r_mem_q [FIFO_DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [AW:0]       r_count;
  state_t            r_state;
  logic [1:0]        r_phase;
  logic [CW-1:0]     r_hcnt;
  logic [DATA_W-1:0] r_hold_i;
  logic [DATA_W-1:0] r_hold_q;

  logic              w_push;
  logic              w_pop;
  logic              w_last;
  logic              w_emit;
  logic              w_neg;
  logic              w_is_min;
  logic [DATA_W-1:0] w_src_i;
  logic [DATA_W-1:0] w_src_q;
  logic [DATA_W-1:0] w_sel;
  logic [DATA_W-1:0] w_mix;

  assign empty    = (r_count == '0);
  assign in_ready = (r_count != FULL_CNT);
  assign w_push   = in_valid && in_ready;

  // r_hcnt is the hold index of the output already emitted; the edge after the last one decides pop/idle.
  assign w_last = (r_hcnt == LAST_CNT);
  assign w_pop  = enable && !empty && ((r_state == IDLE) || w_last);
  assign w_emit = w_pop || ((r_state == RUN) && !w_last);

  assign w_src_i = w_pop ? r_mem_i[r_rd_ptr] : r_hold_i;
  assign w_src_q = w_pop ? r_mem_q[r_rd_ptr] : r_hold_q;

  always_comb begin
    w_sel    = r_phase[0] ? w_src_q : w_src_i;
    w_neg    = (INV == 0) ? (r_phase == 2'd1 || r_phase == 2'd2) : r_phase[1];
    w_is_min = (w_sel == MIN_V);
    w_mix    = w_sel;
    if (w_neg) begin
      w_mix = w_is_min ? MAX_V : -w_sel;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (w_push) begin
      r_mem_i[r_wr_ptr] <= i_signal;
      r_mem_q[r_wr_ptr] <= q_signal;
    end
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_phase   <= 2'd0;
      r_hcnt    <= '0;
      r_hold_i  <= '0;
      r_hold_q  <= '0;
      valid     <= 1'b0;
      rf_output <= '0;
      underrun  <= 1'b0;
    end else begin
      underrun <= 1'b0;
      if (w_emit) begin
        r_state   <= RUN;
        valid     <= 1'b1;
        rf_output <= w_mix;
        r_phase   <= r_phase + 2'd1;
        r_hcnt    <= w_pop ? '0 : r_hcnt + CW'(1);
        if (w_pop) begin
          r_hold_i <= r_mem_i[r_rd_ptr];
          r_hold_q <= r_mem_q[r_rd_ptr];
        end
      end else begin
        r_state   <= IDLE;
        valid     <= 1'b0;
        rf_output <= '0;
        r_phase   <= 2'd0;
        r_hcnt    <= '0;
        // Starvation is only reported when the sample ran out while still enabled.
        if ((r_state == RUN) && enable) underrun <= 1'b1;
      end
    end
  end

`ifdef DUC_SAT_CNT_EN
  logic [15:0] r_sat_cnt;
  logic        w_sat;

  assign w_sat     = w_emit && w_neg && w_is_min;
  assign sat_count = r_sat_cnt;

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      r_sat_cnt <= 16'd0;
    end else if (w_sat && (r_sat_cnt != 16'hFFFF)) begin
      r_sat_cnt <= r_sat_cnt + 16'd1;
    end
  end
`endif

endmodule
